// File: rtl/lif_pkg.sv
// Shared constants and types for the two-neuron LIF address-event encoder.
package lif_pkg;

  localparam int TS_W_DEF  = 6;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    NEURON0 = 1'b0,
    NEURON1 = 1'b1
  } neuron_id_e;

  // One event word is {id, timestamp, lost}.
  function automatic int evt_w(input int ts_w);
    return ts_w + 2;
  endfunction

endpackage

// File: rtl/lif_aer_encoder_if.sv
// Valid/ready event stream between the encoder (master) and its consumer (slave).
interface lif_aer_encoder_if #(
  parameter int EVT_W = lif_pkg::evt_w(lif_pkg::TS_W_DEF)
) ();

  logic [EVT_W-1:0] ev_data;
  logic             ev_valid;
  logic             ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);

endinterface

// File: rtl/lif_evt_fifo.sv
// Event FIFO with up to two writes and one read per cycle; occupancy is registered.
module lif_evt_fifo
  import lif_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int EVT_W = evt_w(TS_W_DEF),
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push0_i,
  input  logic             push1_i,
  input  logic [EVT_W-1:0] wdata0_i,
  input  logic [EVT_W-1:0] wdata1_i,
  input  logic             ready_i,
  output logic [EVT_W-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    occ_o
);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, wptr1_s;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             pop_s;
  logic [1:0]       n_push_s;

  // push1_i is only ever asserted together with push0_i, so it lands one slot later.
  always_comb begin
    pop_s    = (occ_q != {CW{1'b0}}) && ready_i;
    wptr1_s  = wptr_q + AW'(1);
    n_push_s = {1'b0, push0_i} + {1'b0, push1_i};
    wptr_d   = wptr_q + AW'(n_push_s);
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    occ_d = occ_q + CW'(n_push_s) - CW'(pop_s);
  end

  always_ff @(posedge clk_i) begin
    if (push0_i) begin
      mem_q[wptr_q] <= wdata0_i;
    end
    if (push1_i) begin
      mem_q[wptr1_s] <= wdata1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      occ_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (occ_q != {CW{1'b0}});
  assign full_o  = (occ_q == CW'(DEPTH));
  assign occ_o   = occ_q;

endmodule

// File: rtl/lif_aer_encoder.sv
// Two-neuron spike to address-event encoder: timestamping, arbitration into the
// event FIFO, sticky loss marking and a saturating drop counter.
module lif_aer_encoder
  import lif_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  localparam int EVT_W = evt_w(TS_W),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      spike0,
  input  logic                      spike1,
  lif_aer_encoder_if.master         ev_if,
  output logic                      fifo_full,
  output logic [7:0]                drop_cnt
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             lost_q, lost_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]    occ_s, free_s;
  logic             s0_s, s1_s, acc0_s, acc1_s;
  logic [1:0]       n_drop_s;
  logic [8:0]       drop_sum_s;
  logic             push0_s, push1_s;
  logic [EVT_W-1:0] w0_s, w1_s;

  // Free space ignores a same-cycle pop, so the FIFO can never be overfilled.
  always_comb begin
    s0_s     = en & spike0;
    s1_s     = en & spike1;
    free_s   = DEPTH_C - occ_s;
    acc0_s   = 1'b0;
    acc1_s   = 1'b0;
    n_drop_s = 2'd0;
    if (s0_s && s1_s) begin
      if (free_s >= CW'(2)) begin
        acc0_s = 1'b1;
        acc1_s = 1'b1;
      end else if (free_s == CW'(1)) begin
        acc0_s   = 1'b1;
        n_drop_s = 2'd1;
      end else begin
        n_drop_s = 2'd2;
      end
    end else if (s0_s || s1_s) begin
      if (free_s != {CW{1'b0}}) begin
        acc0_s = s0_s;
        acc1_s = s1_s;
      end else begin
        n_drop_s = 2'd1;
      end
    end else begin
      n_drop_s = 2'd0;
    end
  end

  // The first written entry carries the pending loss mark; a second one never does.
  always_comb begin
    push0_s    = acc0_s | acc1_s;
    push1_s    = acc0_s & acc1_s;
    w0_s       = {(acc0_s ? 1'(NEURON0) : 1'(NEURON1)), ts_q, lost_q};
    w1_s       = {1'(NEURON1), ts_q, 1'b0};
    drop_sum_s = {1'b0, drop_cnt_q} + {7'd0, n_drop_s};
    if (drop_sum_s[8]) begin
      drop_cnt_d = 8'hFF;
    end else begin
      drop_cnt_d = drop_sum_s[7:0];
    end
    if (n_drop_s != 2'd0) begin
      lost_d = 1'b1;
    end else if (push0_s) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end
    if (en) begin
      ts_d = ts_q + TS_W'(1);
    end else begin
      ts_d = ts_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= {TS_W{1'b0}};
      lost_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      ts_q       <= ts_d;
      lost_q     <= lost_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  lif_evt_fifo #(
    .DEPTH (DEPTH),
    .EVT_W (EVT_W)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .push0_i  (push0_s),
    .push1_i  (push1_s),
    .wdata0_i (w0_s),
    .wdata1_i (w1_s),
    .ready_i  (ev_if.ev_ready),
    .rdata_o  (ev_if.ev_data),
    .valid_o  (ev_if.ev_valid),
    .full_o   (fifo_full),
    .occ_o    (occ_s)
  );

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_lif_aer_encoder.sv
// Directed bench for lif_aer_encoder with a reference model feeding an event scoreboard.
module tb_lif_aer_encoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       spike0 = 1'b0;
  logic       spike1 = 1'b0;
  logic       fifo_full;
  logic [7:0] drop_cnt;

  lif_aer_encoder_if #(.EVT_W(8)) ev_if ();

  lif_aer_encoder #(.DEPTH(DEPTH), .TS_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike0    (spike0),
    .spike1    (spike1),
    .ev_if     (ev_if),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] sb_q [$];
  logic [5:0] ts_m;
  bit         lost_m;
  int         drop_m;
  bit         chk_on;
  int         tests;
  int         fails;

  function automatic logic [7:0] mk(input bit id, input logic [5:0] ts, input bit l);
    return {id, ts, l};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_m(input bit id);
    sb_q.push_back(mk(id, ts_m, lost_m));
    lost_m = 1'b0;
  endtask

  // One clock: check DUT against the model, advance the model, then cross the edge.
  task automatic step(input bit e, input bit s0, input bit s1, input bit r);
    int occ;
    int nd;
    en = e; spike0 = s0; spike1 = s1; ev_if.ev_ready = r;
    if (chk_on) begin
      chk("valid", ev_if.ev_valid, (sb_q.size() > 0));
      if (sb_q.size() > 0) chk("data", ev_if.ev_data, sb_q[0]);
      chk("full", fifo_full, (sb_q.size() == DEPTH));
      chk("drop", drop_cnt, drop_m);
    end
    if (!rst_n) begin
      sb_q.delete(); ts_m = 6'd0; lost_m = 1'b0; drop_m = 0;
    end else begin
      occ = sb_q.size();
      nd  = 0;
      if (occ > 0 && r) void'(sb_q.pop_front());
      if (e) begin
        if (s0 && s1) begin
          if (DEPTH - occ >= 2) begin push_m(1'b0); push_m(1'b1); end
          else if (DEPTH - occ == 1) begin push_m(1'b0); nd = 1; end
          else nd = 2;
        end else if (s0 || s1) begin
          if (DEPTH - occ >= 1) push_m(s1);
          else nd = 1;
        end
        if (nd > 0) lost_m = 1'b1;
        drop_m = (drop_m + nd > 255) ? 255 : drop_m + nd;
        ts_m = ts_m + 6'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input bit v, input logic [7:0] d);
    chk({tag, "_valid"}, ev_if.ev_valid, v);
    if (v) chk({tag, "_data"}, ev_if.ev_data, d);
  endtask

  // Reset cycle with live spikes that must not be captured.
  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("rst_valid", ev_if.ev_valid, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_drop", drop_cnt, 8'd0);
  endtask

  initial begin
    tests = 0; fails = 0; chk_on = 1'b0;
    ev_if.ev_ready = 1'b0;
    sb_q.delete(); ts_m = 6'd0; lost_m = 1'b0; drop_m = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_on = 1'b1;
    do_reset();

    // single spike0 at ts=5, latency 1 then drained
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r031", 1'b1, 8'h0A);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    expect_head("r031_empty", 1'b0, 8'h00);

    // double spike at ts=3
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_head("r032_a", 1'b1, 8'h06);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    expect_head("r032_b", 1'b1, 8'h86);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    expect_head("r032_empty", 1'b0, 8'h00);

    // fill to full, one drop, disabled spikes ignored, drain, lost mark
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("r033_full", fifo_full, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("r033_drop", drop_cnt, 8'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r033_en0_drop", drop_cnt, 8'd1);
    for (int i = 0; i < 4; i++) begin
      expect_head("r033_drain", 1'b1, 8'(2 * i));
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r033_lost", 1'b1, 8'h15);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // free=1 with both spikes at ts=7
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("r034_drop", drop_cnt, 8'd1);
    chk("r034_full", fifo_full, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    expect_head("r034_lost", 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    expect_head("r034_pushpop", 1'b1, 8'h9A);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // timestamp wrap and en=0 hold
    do_reset();
    for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r035_ts63", 1'b1, 8'h7E);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r035_wrap", 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("r035_hold_drop", drop_cnt, 8'd0);
    expect_head("r035_hold_empty", 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r035_held_ts", 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // double drops until drop_cnt saturates, then reset while full
    do_reset();
    for (int i = 0; i < 130; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_drop", drop_cnt, 8'd255);
    do_reset();

    // reset with three events queued
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_head("r036_pre", 1'b1, 8'h00);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_head("r036_ts0", 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    expect_head("r036_empty", 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
